// File: rtl/gol_pkg.sv
// Shared constants and state encoding for the Game of Life generation engine.
// Seed pattern: one full column and one full row of live cells.
package gol_pkg;

  localparam int GOL_WIDTH  = 50;
  localparam int GOL_HEIGHT = 40;
  localparam int SEED_COL   = 10;
  localparam int SEED_ROW   = 5;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOAD,
    RUN,
    WAIT_SWAP
  } gol_state_e;

endpackage

// File: rtl/gol_if.sv
// Control, status and display-read signals between the engine and its users.
// The engine is the slave; the tick counter / draw logic side is the master.
interface gol_if;

  logic        step;
  logic        frame_start;
  logic [10:0] rd_x;
  logic [10:0] rd_y;
  logic        rd_cell;
  logic        busy;
  logic        step_dropped;
  logic        swapped;
  logic [15:0] gen_count;

  modport master (
    output step, frame_start, rd_x, rd_y,
    input  rd_cell, busy, step_dropped, swapped, gen_count
  );

  modport slave (
    input  step, frame_start, rd_x, rd_y,
    output rd_cell, busy, step_dropped, swapped, gen_count
  );

endinterface

// File: rtl/gol_generation_engine_row_next.sv
// Combinational B3/S23 update of one row from its three-row window.
// Rows are padded with a dead cell on each side so edges never wrap.
module gol_row_next
  import gol_pkg::*;
#(
  parameter int WIDTH = GOL_WIDTH
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] next_row
);

  logic [WIDTH+1:0] p, c, n;
  logic [3:0]       cnt;

  assign p = {1'b0, prev, 1'b0};
  assign c = {1'b0, cur, 1'b0};
  assign n = {1'b0, nxt, 1'b0};

  always_comb begin
    next_row = '0;
    cnt      = '0;
    for (int x = 0; x < WIDTH; x++) begin
      cnt = 4'(p[x]) + 4'(p[x+1]) + 4'(p[x+2])
          + 4'(c[x]) + 4'(c[x+2])
          + 4'(n[x]) + 4'(n[x+1]) + 4'(n[x+2]);
      next_row[x] = (cnt == 4'd3) || (c[x+1] && cnt == 4'd2);
    end
  end

endmodule

// File: rtl/gol_generation_engine.sv
// Double-buffered Game of Life engine: computes a generation row by row
// into the back bank and serves registered cell reads from the front bank.
module gol_generation_engine
  import gol_pkg::*;
#(
  parameter int WIDTH         = GOL_WIDTH,
  parameter int HEIGHT        = GOL_HEIGHT,
  parameter bit SWAP_ON_FRAME = 1'b1
) (
  input logic  Clk,
  input logic  Reset,
  gol_if.slave bus
);

  localparam int AW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  gol_state_e       state;
  logic             front;
  logic [AW-1:0]    row;
  logic [WIDTH-1:0] prev, cur, nxt;
  logic [WIDTH-1:0] next_row;
  logic [WIDTH-1:0] disp_row;
  logic [WIDTH-1:0] mem [2][HEIGHT];
  logic [15:0]      gen_count;
  logic             rd_cell;
  logic             step_dropped;
  logic             busy;
  logic             do_swap;
  logic             last_row;

  function automatic logic [WIDTH-1:0] seed_row(input logic [AW-1:0] y);
    logic [WIDTH-1:0] r;
    for (int x = 0; x < WIDTH; x++)
      r[x] = (x == SEED_COL) || (int'(y) == SEED_ROW);
    return r;
  endfunction

  // Rows past the bottom edge read as dead.
  function automatic logic [WIDTH-1:0] front_row(input int idx);
    logic [AW-1:0] a;
    a = AW'(idx);
    return (idx < HEIGHT) ? mem[front][a] : '0;
  endfunction

  gol_row_next #(.WIDTH(WIDTH)) u_row_next (
    .prev     (prev),
    .cur      (cur),
    .nxt      (nxt),
    .next_row (next_row)
  );

  assign busy     = (state != IDLE);
  assign last_row = (int'(row) == HEIGHT - 1);
  assign do_swap  = !Reset && (state == WAIT_SWAP)
                 && (bus.frame_start || !SWAP_ON_FRAME);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= INIT;
      front        <= 1'b0;
      row          <= '0;
      prev         <= '0;
      cur          <= '0;
      nxt          <= '0;
      gen_count    <= '0;
      step_dropped <= 1'b0;
    end else begin
      step_dropped <= bus.step && busy;
      unique case (state)
        INIT: begin
          row <= last_row ? '0 : row + 1'b1;
          if (last_row) state <= IDLE;
        end
        IDLE: begin
          if (bus.step) begin
            state <= LOAD;
            row   <= '0;
          end
        end
        LOAD: begin
          if (row == '0) begin
            prev <= '0;
            cur  <= front_row(0);
            row  <= AW'(1);
          end else begin
            nxt   <= front_row(1);
            row   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          prev <= cur;
          cur  <= nxt;
          nxt  <= front_row(int'(row) + 2);
          row  <= last_row ? '0 : row + 1'b1;
          if (last_row) state <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (do_swap) begin
            front     <= ~front;
            gen_count <= gen_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == INIT)
        mem[1'b0][row] <= seed_row(row);
      else if (state == RUN)
        mem[~front][row] <= next_row;
    end
  end

  assign disp_row = mem[front][bus.rd_y[AW-1:0]];

  always_ff @(posedge Clk) begin
    if (Reset || state == INIT)
      rd_cell <= 1'b0;
    else if (int'(bus.rd_x) < WIDTH && int'(bus.rd_y) < HEIGHT)
      rd_cell <= disp_row[bus.rd_x[XW-1:0]];
    else
      rd_cell <= 1'b0;
  end

  assign bus.rd_cell      = rd_cell;
  assign bus.busy         = busy;
  assign bus.step_dropped = step_dropped;
  assign bus.swapped      = do_swap;
  assign bus.gen_count    = gen_count;

endmodule
